// File: rtl/task_injector.sv
// task_injector: producer side of the scheduler task write port.
// Buffers host tasks and re-queues exchanged tasks returned by the scheduler,
// issues them one at a time with strict exchange priority, holds off during
// the control repair period and spaces writes by GAP idle cycles.
module task_injector #(
    parameter int unsigned W       = 42,
    parameter int unsigned H_DEPTH = 16,
    parameter int unsigned E_DEPTH = 4,
    parameter int unsigned GAP     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       host_valid,
    input  logic [W-2:0]               host_task,
    output logic                       host_ready,
    input  logic                       v_exch,
    input  logic [W-2:0]               task_exch,
    input  logic                       CTRL_RP,
    output logic                       wr,
    output logic [W-2:0]               task_in,
    output logic                       exch_ovf,
    output logic [$clog2(H_DEPTH):0]   host_cnt,
    output logic [$clog2(E_DEPTH):0]   exch_cnt
);

    localparam int unsigned HAW = $clog2(H_DEPTH);
    localparam int unsigned EAW = $clog2(E_DEPTH);

    localparam logic [HAW:0] H_FULL = (HAW + 1)'(H_DEPTH);
    localparam logic [EAW:0] E_FULL = (EAW + 1)'(E_DEPTH);
    localparam logic [3:0]   GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAPW  = 2'd2;

    logic [1:0]     state;
    logic [3:0]     gap_cnt;

    logic [W-2:0]   host_mem [H_DEPTH];
    logic [HAW-1:0] host_wp;
    logic [HAW-1:0] host_rp;

    logic [W-2:0]   exch_mem [E_DEPTH];
    logic [EAW-1:0] exch_wp;
    logic [EAW-1:0] exch_rp;

    logic slot_open;
    logic issue;
    logic host_push;
    logic host_pop;
    logic exch_push;
    logic exch_pop;

    // Decide whether this cycle may launch a write, and what moves where.
    // A GAPW cycle whose counter has run out is the last idle cycle of the
    // gap and decides the next write exactly as IDLE would, so the gap is
    // exactly GAP cycles; with GAP=0 ISSUE itself acts as IDLE.
    always_comb begin
        slot_open = 1'b0;
        case (state)
            IDLE:    slot_open = 1'b1;
            ISSUE:   slot_open = (GAP == 0);
            GAPW:    slot_open = (gap_cnt == '0);
            default: slot_open = 1'b0;
        endcase
        host_ready = rst & (host_cnt != H_FULL);
        issue      = slot_open & ~CTRL_RP & ((exch_cnt != '0) | (host_cnt != '0));
        exch_pop   = issue & (exch_cnt != '0);
        host_pop   = issue & (exch_cnt == '0);
        host_push  = host_valid & host_ready;
        exch_push  = v_exch & ((exch_cnt != E_FULL) | exch_pop);
    end

    // Host FIFO storage.
    always_ff @(posedge clk) begin
        if (host_push) begin
            host_mem[host_wp] <= host_task;
        end
    end

    // Exchange FIFO storage.
    always_ff @(posedge clk) begin
        if (rst && exch_push) begin
            exch_mem[exch_wp] <= task_exch;
        end
    end

    // Host FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            host_wp  <= '0;
            host_rp  <= '0;
            host_cnt <= '0;
        end else begin
            if (host_push) host_wp <= host_wp + 1'b1;
            if (host_pop)  host_rp <= host_rp + 1'b1;
            case ({host_push, host_pop})
                2'b10:   host_cnt <= host_cnt + 1'b1;
                2'b01:   host_cnt <= host_cnt - 1'b1;
                default: host_cnt <= host_cnt;
            endcase
        end
    end

    // Exchange FIFO pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exch_wp  <= '0;
            exch_rp  <= '0;
            exch_cnt <= '0;
            exch_ovf <= 1'b0;
        end else begin
            if (exch_push) exch_wp <= exch_wp + 1'b1;
            if (exch_pop)  exch_rp <= exch_rp + 1'b1;
            case ({exch_push, exch_pop})
                2'b10:   exch_cnt <= exch_cnt + 1'b1;
                2'b01:   exch_cnt <= exch_cnt - 1'b1;
                default: exch_cnt <= exch_cnt;
            endcase
            if (v_exch && !exch_push) exch_ovf <= 1'b1;
        end
    end

    // Issue sequencing and gap counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) state <= ISSUE;
                end
                ISSUE: begin
                    if (GAP == 0) begin
                        state <= issue ? ISSUE : IDLE;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAPW;
                    end
                end
                GAPW: begin
                    if (gap_cnt == '0) begin
                        state <= issue ? ISSUE : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered write strobe and task word; the word holds between writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr      <= 1'b0;
            task_in <= '0;
        end else begin
            wr <= issue;
            if (issue) begin
                task_in <= exch_pop ? exch_mem[exch_rp] : host_mem[host_rp];
            end
        end
    end

endmodule

// File: tb/tb_task_injector.sv
// Testbench for task_injector: directed table, hand sequences for the
// multi-cycle corners, then randomized traffic against a queue-based model.
module tb_task_injector;

    localparam int unsigned W    = 42;
    localparam int unsigned HD   = 16;
    localparam int unsigned ED   = 4;
    localparam int          GAP1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_valid = 1'b0;
    logic [40:0] host_task = '0;
    logic        v_exch = 1'b0;
    logic [40:0] task_exch = '0;
    logic        CTRL_RP = 1'b0;

    logic        host_ready, wr, exch_ovf;
    logic [40:0] task_in;
    logic [4:0]  host_cnt;
    logic [2:0]  exch_cnt;

    logic        host_ready0, wr0, exch_ovf0;
    logic [40:0] task_in0;
    logic [4:0]  host_cnt0;
    logic [2:0]  exch_cnt0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task_injector #(.W(W), .H_DEPTH(HD), .E_DEPTH(ED), .GAP(1)) u_dut (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_task(host_task),
        .host_ready(host_ready), .v_exch(v_exch), .task_exch(task_exch),
        .CTRL_RP(CTRL_RP), .wr(wr), .task_in(task_in), .exch_ovf(exch_ovf),
        .host_cnt(host_cnt), .exch_cnt(exch_cnt)
    );

    task_injector #(.W(W), .H_DEPTH(HD), .E_DEPTH(ED), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_task(host_task),
        .host_ready(host_ready0), .v_exch(v_exch), .task_exch(task_exch),
        .CTRL_RP(CTRL_RP), .wr(wr0), .task_in(task_in0), .exch_ovf(exch_ovf0),
        .host_cnt(host_cnt0), .exch_cnt(exch_cnt0)
    );

    // Reference model of the GAP=1 instance: two plain queues plus the edge
    // index of the last issue; a new issue needs GAP edges in between.
    logic [40:0] mh[$];
    logic [40:0] me[$];
    int          edge_n = 0;
    int          last_issue = -100;
    logic        m_wr = 1'b0;
    logic        m_ovf = 1'b0;
    logic [40:0] m_task = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int hs;
        int es;
        logic go;
        logic [40:0] word;
        hs = mh.size();
        es = me.size();
        if (!rst) begin
            mh.delete();
            me.delete();
            m_wr = 1'b0;
            m_task = '0;
            m_ovf = 1'b0;
            last_issue = -100;
        end else begin
            go = !CTRL_RP && (hs + es > 0) && (edge_n >= last_issue + 1 + GAP1);
            m_wr = go;
            if (go) begin
                if (es > 0) word = me.pop_front();
                else        word = mh.pop_front();
                m_task = word;
                last_issue = edge_n;
            end
            if (host_valid && hs != HD) mh.push_back(host_task);
            if (v_exch) begin
                if (es != ED || (go && es > 0)) me.push_back(task_exch);
                else m_ovf = 1'b1;
            end
        end
        edge_n++;
    endtask

    task automatic check_model();
        chk("m_wr",      64'(wr),         64'(m_wr));
        chk("m_task_in", 64'(task_in),    64'(m_task));
        chk("m_hcnt",    64'(host_cnt),   64'(mh.size()));
        chk("m_ecnt",    64'(exch_cnt),   64'(me.size()));
        chk("m_ovf",     64'(exch_ovf),   64'(m_ovf));
        chk("m_ready",   64'(host_ready), 64'(rst && mh.size() != HD));
    endtask

    task automatic cyc(input logic r, input logic hv, input logic [40:0] ht,
                       input logic ve, input logic [40:0] te, input logic rp);
        @(negedge clk);
        rst = r; host_valid = hv; host_task = ht;
        v_exch = ve; task_exch = te; CTRL_RP = rp;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    typedef struct {
        logic        rst;
        logic        hv;
        logic [40:0] ht;
        logic        ve;
        logic [40:0] te;
        logic        rp;
        logic        e_wr;
        logic [40:0] e_task;
        int          e_hcnt;
        int          e_ecnt;
    } vec_t;

    function automatic vec_t mk(input logic hv, input logic [40:0] ht, input logic ve,
                                input logic [40:0] te, input logic rp, input logic e_wr,
                                input logic [40:0] e_task, input int e_hcnt, input int e_ecnt);
        vec_t v;
        v.rst = 1'b1; v.hv = hv; v.ht = ht; v.ve = ve; v.te = te; v.rp = rp;
        v.e_wr = e_wr; v.e_task = e_task; v.e_hcnt = e_hcnt; v.e_ecnt = e_ecnt;
        return v;
    endfunction

    vec_t        vt [13];
    logic [40:0] got[$];
    logic [40:0] got0[$];
    logic [7:0]  pat1;
    logic [7:0]  pat0;
    logic [40:0] rt;
    logic [40:0] re;

    initial begin
        // single host task, then exchange priority over two queued host tasks
        vt[0]  = mk(1, 41'h123, 0, '0,       0, 0, 41'h000, 1, 0);
        vt[1]  = mk(0, '0,      0, '0,       0, 1, 41'h123, 0, 0);
        vt[2]  = mk(0, '0,      0, '0,       0, 0, 41'h123, 0, 0);
        vt[3]  = mk(0, '0,      0, '0,       0, 0, 41'h123, 0, 0);
        vt[4]  = mk(1, 41'h111, 0, '0,       1, 0, 41'h123, 1, 0);
        vt[5]  = mk(1, 41'h222, 0, '0,       1, 0, 41'h123, 2, 0);
        vt[6]  = mk(0, '0,      1, 41'hAAA,  1, 0, 41'h123, 2, 1);
        vt[7]  = mk(0, '0,      0, '0,       0, 1, 41'hAAA, 2, 0);
        vt[8]  = mk(0, '0,      0, '0,       0, 0, 41'hAAA, 2, 0);
        vt[9]  = mk(0, '0,      0, '0,       0, 1, 41'h111, 1, 0);
        vt[10] = mk(0, '0,      0, '0,       0, 0, 41'h111, 1, 0);
        vt[11] = mk(0, '0,      0, '0,       0, 1, 41'h222, 0, 0);
        vt[12] = mk(0, '0,      0, '0,       0, 0, 41'h222, 0, 0);

        // reset state
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("rst_wr",    64'(wr),          64'(0));
        chk("rst_task",  64'(task_in),     64'(0));
        chk("rst_hcnt",  64'(host_cnt),    64'(0));
        chk("rst_ready", 64'(host_ready),  64'(0));
        chk("rst_wr0",   64'(wr0),         64'(0));
        chk("rst_ovf0",  64'(exch_ovf0),   64'(0));

        for (int i = 0; i < 13; i++) begin
            cyc(vt[i].rst, vt[i].hv, vt[i].ht, vt[i].ve, vt[i].te, vt[i].rp);
            chk($sformatf("vec%0d_wr", i),   64'(wr),       64'(vt[i].e_wr));
            chk($sformatf("vec%0d_task", i), 64'(task_in),  64'(vt[i].e_task));
            chk($sformatf("vec%0d_hcnt", i), 64'(host_cnt), 64'(vt[i].e_hcnt));
            chk($sformatf("vec%0d_ecnt", i), 64'(exch_cnt), 64'(vt[i].e_ecnt));
        end

        // GAP spacing: three consecutive host pushes on both instances
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        pat1 = 8'b0010_1010;
        pat0 = 8'b0000_1110;
        got.delete();
        got0.delete();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, k < 3, 41'h0B00 + 41'(k), 1'b0, '0, 1'b0);
            chk($sformatf("gap1_wr%0d", k), 64'(wr),  64'(pat1[k]));
            chk($sformatf("gap0_wr%0d", k), 64'(wr0), 64'(pat0[k]));
            if (wr)  got.push_back(task_in);
            if (wr0) got0.push_back(task_in0);
        end
        chk("gap1_n", 64'(got.size()),  64'(3));
        chk("gap0_n", 64'(got0.size()), 64'(3));
        for (int k = 0; k < 3; k++) begin
            if (k < got.size())  chk("gap1_order", 64'(got[k]),  64'(41'h0B00 + 41'(k)));
            if (k < got0.size()) chk("gap0_order", 64'(got0[k]), 64'(41'h0B00 + 41'(k)));
        end

        // repair period holds off three queued tasks for ten cycles
        idle(2);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, i < 3, 41'h400 + 41'(i), 1'b0, '0, 1'b1);
            chk("rp_hold_wr", 64'(wr), 64'(0));
        end
        chk("rp_hcnt", 64'(host_cnt), 64'(3));
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("rp_first_wr",   64'(wr),      64'(1));
        chk("rp_first_task", 64'(task_in), 64'(41'h400));
        idle(6);

        // exchange overflow: five returns into a depth-4 queue
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0, 1'b1, 41'hE01 + 41'(i), 1'b1);
        chk("ovf_ecnt", 64'(exch_cnt), 64'(4));
        chk("ovf_flag", 64'(exch_ovf), 64'(1));
        got.delete();
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
            if (wr) got.push_back(task_in);
        end
        chk("ovf_n", 64'(got.size()), 64'(4));
        for (int k = 0; k < 4; k++)
            if (k < got.size()) chk("ovf_order", 64'(got[k]), 64'(41'hE01 + 41'(k)));
        chk("ovf_sticky", 64'(exch_ovf), 64'(1));

        // fill host FIFO, then reset while a write is in flight
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 41'h600 + 41'(i), 1'b0, '0, 1'b1);
        chk("full_ready", 64'(host_ready), 64'(0));
        chk("full_hcnt",  64'(host_cnt),   64'(16));
        cyc(1'b1, 1'b1, 41'h6FF, 1'b0, '0, 1'b1);
        chk("full_nopush", 64'(host_cnt), 64'(16));
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("mid_wr",   64'(wr),       64'(1));
        chk("mid_task", 64'(task_in),  64'(41'h600));
        chk("mid_hcnt", 64'(host_cnt), 64'(15));
        chk("mid_wr0",  64'(wr0),      64'(1));
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("mrst_wr",    64'(wr),         64'(0));
        chk("mrst_wr0",   64'(wr0),        64'(0));
        chk("mrst_hcnt",  64'(host_cnt),   64'(0));
        chk("mrst_hcnt0", 64'(host_cnt0),  64'(0));
        chk("mrst_ecnt",  64'(exch_cnt),   64'(0));
        chk("mrst_ovf",   64'(exch_ovf),   64'(0));
        chk("mrst_ready", 64'(host_ready), 64'(0));
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("rel_ready", 64'(host_ready), 64'(1));
        chk("rel_wr",    64'(wr),         64'(0));

        // randomized traffic with periodic repair windows and rare resets
        for (int i = 0; i < 3000; i++) begin
            rt = 41'({$urandom(), $urandom()});
            re = 41'({$urandom(), $urandom()});
            cyc($urandom_range(0, 149) != 0,
                $urandom_range(0, 3) != 0, rt,
                $urandom_range(0, 3) == 0, re,
                (i % 200) < 45 || $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
